// File: rtl/alu_flags_unit.sv
// Datapath ALU with registered NZCV flags and the high byte of the last multiply.
// The result is combinational; flag and MUL_HI state advance only on qualified slow-clock strobes.
module alu_flags_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             ARST,
  input  logic             SLOW_CLOCK_STRB,
  input  logic             alu_en,
  input  logic [7:0]       alu_sel,
  input  logic [WIDTH-1:0] R0_VAL,
  input  logic [WIDTH-1:0] R1_VAL,
  input  logic [WIDTH-1:0] R2_VAL,
  input  logic [WIDTH-1:0] R3_VAL,
  output logic [WIDTH-1:0] ALU_RESULT,
  output logic             ALU_BUS_EN,
  output logic [3:0]       condition_flags,
  output logic [WIDTH-1:0] MUL_HI
);

  localparam int unsigned SW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD = 4'd4,
    OP_SUB = 4'd5,
    OP_LSL = 4'd6,
    OP_LSR = 4'd7,
    OP_ASR = 4'd8,
    OP_MUL = 4'd9
  } op_t;

  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SW-1:0]    n;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH:0]   lsl_ext;
  logic [WIDTH:0]   lsr_ext;
  logic [WIDTH:0]   asr_ext;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res;
  logic             valid;
  logic             c_next;
  logic             v_next;

  assign op = op_t'(alu_sel[7:4]);
  assign n  = b[SW-1:0];

  always_comb begin
    a = '0;
    b = '0;
    case (alu_sel[3:2])
      2'd0:    a = R0_VAL;
      2'd1:    a = R1_VAL;
      2'd2:    a = R2_VAL;
      default: a = R3_VAL;
    endcase
    case (alu_sel[1:0])
      2'd0:    b = R0_VAL;
      2'd1:    b = R1_VAL;
      2'd2:    b = R2_VAL;
      default: b = R3_VAL;
    endcase
  end

  // Shifts run on a one-bit-extended operand so the carry falls out as the
  // extension bit, avoiding a variable bit-select of A.
  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    lsl_ext  = {1'b0, a} << n;
    lsr_ext  = {a, 1'b0} >> n;
    asr_ext  = $signed({a, 1'b0}) >>> n;
    prod     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  end

  always_comb begin
    res    = '0;
    valid  = 1'b0;
    c_next = condition_flags[1];
    v_next = condition_flags[0];
    case (op)
      OP_ADD: begin
        valid  = 1'b1;
        res    = sum_ext[WIDTH-1:0];
        c_next = sum_ext[WIDTH];
        v_next = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        valid  = 1'b1;
        res    = diff_ext[WIDTH-1:0];
        c_next = ~diff_ext[WIDTH];
        v_next = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_LSL: begin
        valid = 1'b1;
        res   = lsl_ext[WIDTH-1:0];
        if (n != '0) c_next = lsl_ext[WIDTH];
      end
      OP_LSR: begin
        valid = 1'b1;
        res   = lsr_ext[WIDTH:1];
        if (n != '0) c_next = lsr_ext[0];
      end
      OP_ASR: begin
        valid = 1'b1;
        res   = asr_ext[WIDTH:1];
        if (n != '0) c_next = asr_ext[0];
      end
      OP_MUL: begin
        valid  = 1'b1;
        res    = prod[WIDTH-1:0];
        c_next = |prod[2*WIDTH-1:WIDTH];
      end
      default: begin
        valid = 1'b0;
      end
    endcase
  end

  assign ALU_BUS_EN = alu_en & valid;
  assign ALU_RESULT = ALU_BUS_EN ? res : '0;

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      condition_flags <= '0;
      MUL_HI          <= '0;
    end else if (SLOW_CLOCK_STRB && ALU_BUS_EN) begin
      condition_flags <= {res[WIDTH-1], (res == '0), c_next, v_next};
      if (op == OP_MUL) MUL_HI <= prod[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: doc/alu_flags_unit.md
Name: alu_flags_unit

Overview:
- Datapath ALU that consumes the control-unit outputs alu_en and alu_sel (alu_sel = instruction bits [9:2]) and the four general-register values.
- Produces the combinational result driven onto the register-write path.
- Holds the NZCV condition-flag register, which feeds back to the control unit for conditional-branch evaluation.
- Holds the high byte of the last multiply.

Parameters:
WIDTH, 8, datapath width in bits; shift amount uses the low log2(WIDTH) bits of operand B.

Ports:
CLK  in  1  system clock
ARST  in  1  asynchronous reset, active high
SLOW_CLOCK_STRB  in  1  one-CLK-wide strobe; every state update is qualified by it
alu_en  in  1  ALU operation active this slow step
alu_sel  in  8  [7:4] op code, [3:2] operand A register index, [1:0] operand B register index
R0_VAL  in  WIDTH  register 0 contents
R1_VAL  in  WIDTH  register 1 contents
R2_VAL  in  WIDTH  register 2 contents
R3_VAL  in  WIDTH  register 3 contents
ALU_RESULT  out  WIDTH  combinational result
ALU_BUS_EN  out  1  result valid / drive enable
condition_flags  out  4  registered flags: [3]=N, [2]=Z, [1]=C, [0]=V
MUL_HI  out  WIDTH  registered upper half of last MUL product

Behaviour:
- Reset is async active-high. While ARST=1: condition_flags=4'b0000, MUL_HI=0. ALU_RESULT and ALU_BUS_EN are combinational and stay 0 unless alu_en=1.
- Operand select: A = R[alu_sel[3:2]], B = R[alu_sel[1:0]].
- Valid ops are alu_sel[7:4] = 4..9. Any other code counts as invalid.
- ALU_BUS_EN = alu_en AND valid op. ALU_RESULT = 0 when ALU_BUS_EN=0. The result has zero latency: it is valid in the same slow step as alu_en, so the destination register captures it on that step's strobe.
- Op 4, ADD: R = A+B. C = carry out. V = signed overflow (A,B same sign, R sign differs).
- Op 5, SUB: R = A-B. C = 1 when A>=B unsigned (no borrow). V = A,B differ in sign and R sign differs from A.
- Op 6, LSL: shift by n = B[2:0]. C = A[WIDTH-n].
- Op 7, LSR: shift by n = B[2:0]. C = A[n-1].
- Op 8, ASR: shift by n = B[2:0], sign fill. C = A[n-1].
- Shift rules common to ops 6–8: V unchanged. When n=0, R=A and C is unchanged. Upper bits of B are ignored.
- Op 9, MUL: full 2*WIDTH unsigned product P. R = P[WIDTH-1:0]. C = OR of P[2*WIDTH-1:WIDTH]. V unchanged. MUL_HI <= P[2*WIDTH-1:WIDTH].
- N = R[WIDTH-1] and Z = (R==0) for every valid op.
- Flag register update happens only on posedge CLK with SLOW_CLOCK_STRB=1, alu_en=1 and a valid op. Otherwise flags hold.
- MUL_HI updates only under the same qualification with op 9.
- alu_en=1 with STRB=0: result is still driven; no state changes.
- Invalid op with alu_en=1: ALU_BUS_EN=0, result 0, flags and MUL_HI hold.
- ARST mid-operation clears flags and MUL_HI immediately, independent of CLK. The first update after reset release needs a qualified strobe.
- Operand aliasing (A and B the same register) is legal. The destination being one of the sources needs no special handling, because the result is consumed at the strobe edge.
- condition_flags changes only at the strobe edge, so a branch in the following instruction sees the new value.

Test Plan:
- ADD R0=0x7F, R1=0x01, alu_sel=0x41, strobe -> ALU_RESULT=0x80, ALU_BUS_EN=1; after edge condition_flags=4'b1001.
- SUB R2=0x05, R3=0x05, alu_sel=0x5B, strobe -> ALU_RESULT=0x00, condition_flags=4'b0110.
- LSR R0=0x81 by R1=0x01 (alu_sel=0x71) with prior V=1 -> ALU_RESULT=0x40, condition_flags=4'b0011. Then LSL by B=0x00 (alu_sel=0x60 with R0=0x00) -> ALU_RESULT=0x00, flags=4'b0111 (Z set, C and V held).
- MUL R0=0x10, R1=0x20, alu_sel=0x91 -> ALU_RESULT=0x00, MUL_HI=0x02, condition_flags: N=0, Z=1, C=1, V held.
- Gating and invalid op:
  - alu_en=1, valid ADD, STRB held 0 for 5 CLK -> result driven, flags and MUL_HI unchanged.
  - alu_sel=0xE0 with alu_en=1 -> ALU_BUS_EN=0, ALU_RESULT=0, flags unchanged after strobe.
- Reset: flags=4'b1111 and MUL_HI=0xAB; pulse ARST between CLK edges -> both read 0 before the next edge. The next qualified ADD 0x01+0x01 gives flags=4'b0000 and result 0x02.
